// File: rtl/tile_fb_writer.sv
// Renders the 240x264 tile maze into the back framebuffer, one pixel per clock, column-major.
// A toggle of swap_in starts a fresh frame. A swap during an unfinished scan aborts that scan and raises overrun.
module tile_fb_writer #(
    parameter int          FB_W       = 240,
    parameter int          FB_H       = 264,
    parameter logic [15:0] BLANK_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swap_in,
    output logic [9:0]  map_addr,
    input  logic [5:0]  map_data,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [15:0] addrWrite,
    output logic [7:0]  dataWrite,
    output logic        wr_valid,
    output logic        frame_done,
    output logic        overrun,
    output logic [1:0]  fsm_state
);
    localparam int          TILE_COLS = FB_W / 8;
    localparam logic [15:0] LAST_ADDR = 16'(FB_W * FB_H - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;
    state_t state, state_nx;

    // Handshake: none. There are no stalls.
    // A pixel is committed on every clock where wr_valid=1.
    // When wr_valid=0 the write port is parked at BLANK_ADDR with data 0.
    logic        swap_q, swap_evt, issue, flush;
    logic [7:0]  x, cur_x;
    logic [8:0]  y, cur_y;
    logic [15:0] addr, cur_addr;

    logic        s1_v, s1_last, s2_v, s2_last, s3_v, s3_last;
    logic [2:0]  s1_x3, s1_y3;
    logic [15:0] s1_addr, s2_addr, s3_addr;

    assign swap_evt  = swap_in ^ swap_q;
    assign flush     = swap_evt && (state != IDLE);
    assign issue     = !rst && (swap_evt || state == SCAN);
    assign fsm_state = state;

    // A swap issues pixel 0 in the same cycle, so the restart costs no extra clock.
    always_comb begin
        cur_x    = swap_evt ? 8'd0  : x;
        cur_y    = swap_evt ? 9'd0  : y;
        cur_addr = swap_evt ? 16'd0 : addr;
        map_addr = issue ? 10'(cur_y[8:3] * TILE_COLS + cur_x[7:3]) : 10'd0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (swap_evt) state_nx = SCAN;
            SCAN:    if (swap_evt) state_nx = SCAN;
                     else if (cur_addr == LAST_ADDR) state_nx = DRAIN;
            DRAIN:   if (swap_evt) state_nx = SCAN;
                     else if (s3_v && s3_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            swap_q <= 1'b0;
            x <= 8'd0;
            y <= 9'd0;
            addr <= 16'd0;
        end else begin
            state <= state_nx;
            swap_q <= swap_in;
            if (issue) begin
                if (cur_addr == LAST_ADDR) begin
                    x <= 8'd0;
                    y <= 9'd0;
                    addr <= 16'd0;
                end else begin
                    addr <= cur_addr + 16'd1;
                    if (cur_y == 9'(FB_H - 1)) begin
                        y <= 9'd0;
                        x <= cur_x + 8'd1;
                    end else begin
                        y <= cur_y + 9'd1;
                        x <= cur_x;
                    end
                end
            end
        end
    end

    // Stages: s1 waits on map_data, s2 drives rom_addr, s3 lines up with rom_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_last <= 1'b0;
            s1_x3 <= 3'd0;
            s1_y3 <= 3'd0;
            s1_addr <= 16'd0;
            s2_v <= 1'b0;
            s2_last <= 1'b0;
            s2_addr <= 16'd0;
            rom_addr <= 12'd0;
            s3_v <= 1'b0;
            s3_last <= 1'b0;
            s3_addr <= 16'd0;
            wr_valid <= 1'b0;
            addrWrite <= BLANK_ADDR;
            dataWrite <= 8'd0;
            frame_done <= 1'b0;
            overrun <= 1'b0;
        end else begin
            s1_v <= issue;
            s1_last <= (cur_addr == LAST_ADDR);
            s1_x3 <= cur_x[2:0];
            s1_y3 <= cur_y[2:0];
            s1_addr <= cur_addr;

            s2_v <= s1_v && !flush;
            s2_last <= s1_last;
            s2_addr <= s1_addr;
            if (s1_v) rom_addr <= {map_data, s1_y3, s1_x3};

            s3_v <= s2_v && !flush;
            s3_last <= s2_last;
            s3_addr <= s2_addr;

            wr_valid <= s3_v && !flush;
            addrWrite <= (s3_v && !flush) ? s3_addr : BLANK_ADDR;
            dataWrite <= (s3_v && !flush) ? rom_data : 8'd0;
            frame_done <= s3_v && s3_last && !flush;
            overrun <= flush;
        end
    end
endmodule
